// File: rtl/dmem_responder_if.sv
// Load/store request and single-cycle response bundle between the LSU (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write_en;
  logic [1:0]  req_size;
  logic        req_sign_extend;
  logic [31:0] req_write_data;
  logic        rsp_valid;
  logic [31:0] rsp_read_data;
  logic        rsp_error;

  modport master (
    output req_valid, req_addr, req_write_en, req_size, req_sign_extend, req_write_data,
    input  req_ready, rsp_valid, rsp_read_data, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write_en, req_size, req_sign_extend, req_write_data,
    output req_ready, rsp_valid, rsp_read_data, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-lane data memory behind a valid/ready load/store port; response 1 cycle after acceptance, no rsp backpressure.
// DMEM_MISALIGNED_SPLIT_EN: misaligned accesses run a second SPLIT cycle (ready low 1 cycle) instead of erroring.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned XLEN        = 32
) (
  input logic             clk_i,
  input logic             rst_ni,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            rsp_valid_q;
  logic            rsp_error_q;
  logic [XLEN-1:0] rsp_data_q;

  logic            accept;
  logic [2:0]      nbytes;
  logic [3:0]      mask;
  logic [32:0]     last_byte;
  logic            req_misal;
  logic            req_err;
  logic [3:0]      lane_lo;
  logic [XLEN-1:0] wdata_lo;
  logic [AW-1:0]   req_idx;
  logic [5:0]      req_sh;

  logic [AW-1:0]   acc_idx;
  logic [3:0]      acc_lanes;
  logic [XLEN-1:0] acc_wdata;
  logic            acc_we;
  logic [5:0]      cur_sh;
  logic [1:0]      cur_size;
  logic            cur_sext;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] rd_lo;
  logic [XLEN-1:0] rd_hi;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_data;

`ifdef DMEM_MISALIGNED_SPLIT_EN
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;
  state_e          state_q;
  logic [AW-1:0]   split_idx_q;
  logic [1:0]      split_off_q;
  logic [1:0]      split_size_q;
  logic            split_sext_q;
  logic            split_we_q;
  logic [3:0]      split_lanes_q;
  logic [XLEN-1:0] split_wdata_q;
  logic [XLEN-1:0] split_lo_q;

  assign bus.req_ready = (state_q == IDLE);
`else
  assign bus.req_ready = 1'b1;
`endif

  assign accept            = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_error     = rsp_error_q;
  assign bus.rsp_read_data = rsp_data_q;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                             input logic sx);
    case (sz)
      2'd0:    return sx ? {{(XLEN-8){d[7]}}, d[7:0]} : {{(XLEN-8){1'b0}}, d[7:0]};
      2'd1:    return sx ? {{(XLEN-16){d[15]}}, d[15:0]} : {{(XLEN-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Request decode; the range check uses 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (bus.req_size)
      2'd0:    begin nbytes = 3'd1; mask = 4'b0001; end
      2'd1:    begin nbytes = 3'd2; mask = 4'b0011; end
      default: begin nbytes = 3'd4; mask = 4'b1111; end
    endcase
    req_sh    = {1'b0, bus.req_addr[1:0], 3'b000};
    last_byte = {1'b0, bus.req_addr} + {30'd0, nbytes} - 33'd1;
    req_misal = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    req_err   = (bus.req_size == 2'd3) || (last_byte >= LIMIT);
`ifndef DMEM_MISALIGNED_SPLIT_EN
    req_err   = req_err || req_misal;
`endif
    lane_lo   = mask << bus.req_addr[1:0];
    wdata_lo  = bus.req_write_data << req_sh;
    req_idx   = bus.req_addr[AW+1:2];
  end

  // Single memory port: the request's word in IDLE, the following word during SPLIT.
  always_comb begin
    acc_idx   = req_idx;
    acc_lanes = lane_lo;
    acc_wdata = wdata_lo;
    acc_we    = accept && !req_err && bus.req_write_en;
    cur_sh    = req_sh;
    cur_size  = bus.req_size;
    cur_sext  = bus.req_sign_extend;
`ifdef DMEM_MISALIGNED_SPLIT_EN
    if (state_q == SPLIT) begin
      acc_idx   = split_idx_q;
      acc_lanes = split_lanes_q;
      acc_wdata = split_wdata_q;
      acc_we    = split_we_q;
      cur_sh    = {1'b0, split_off_q, 3'b000};
      cur_size  = split_size_q;
      cur_sext  = split_sext_q;
    end
`endif
  end

  always_comb begin
    rd_word = (32'(acc_idx) < DEPTH_WORDS) ? mem_q[acc_idx] : '0;
    rd_lo   = rd_word;
    rd_hi   = '0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
    if (state_q == SPLIT) begin
      rd_lo = split_lo_q;
      rd_hi = rd_word;
    end
`endif
    rd_shift  = (rd_lo >> cur_sh) | (rd_hi << (6'd32 - cur_sh));
    load_data = extend(rd_shift, cur_size, cur_sext);
  end

  always_ff @(posedge clk_i) begin
    if (acc_we) begin
      for (int l = 0; l < 4; l++) begin
        if (acc_lanes[l]) mem_q[acc_idx][8*l +: 8] <= acc_wdata[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_data_q    <= '0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      state_q       <= IDLE;
      split_idx_q   <= '0;
      split_off_q   <= '0;
      split_size_q  <= '0;
      split_sext_q  <= 1'b0;
      split_we_q    <= 1'b0;
      split_lanes_q <= '0;
      split_wdata_q <= '0;
      split_lo_q    <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      if (state_q == SPLIT) begin
        state_q     <= IDLE;
        rsp_valid_q <= 1'b1;
        rsp_error_q <= 1'b0;
        rsp_data_q  <= split_we_q ? '0 : load_data;
      end else
`endif
      if (accept) begin
        if (req_err) begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b1;
          rsp_data_q  <= '0;
        end
`ifdef DMEM_MISALIGNED_SPLIT_EN
        else if (req_misal) begin
          // Bytes past byte 3 of word W are deferred to lanes 0.. of word W+1.
          state_q       <= SPLIT;
          split_idx_q   <= req_idx + AW'(1);
          split_off_q   <= bus.req_addr[1:0];
          split_size_q  <= bus.req_size;
          split_sext_q  <= bus.req_sign_extend;
          split_we_q    <= bus.req_write_en;
          split_lanes_q <= mask >> (3'd4 - {1'b0, bus.req_addr[1:0]});
          split_wdata_q <= bus.req_write_data >> (6'd32 - req_sh);
          split_lo_q    <= rd_word;
        end
`endif
        else begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_data_q  <= bus.req_write_en ? '0 : load_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] TOP   = 32'(DEPTH * 4);
`ifdef DMEM_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder #(.DEPTH_WORDS(DEPTH), .XLEN(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         split_pend = 1'b0;
  logic [7:0] mdl [DEPTH*4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: memory is a flat byte array; an access is a run of nbytes consecutive bytes.
  function automatic void model(input logic [31:0] a, input bit we, input logic [1:0] sz,
                                input bit sx, input logic [31:0] wd,
                                output logic [31:0] rd, output bit err, output bit split);
    int     nb;
    longint last;
    bit     mis;
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last  = longint'({32'h0, a}) + nb - 1;
    mis   = (nb > 1) && ((a % nb) != 0);
    err   = (sz == 2'd3) || (last >= longint'(DEPTH) * 4) || (!SPLIT_EN && mis);
    split = !err && mis;
    rd    = '0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mdl[a + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) rd |= 32'(mdl[a + k]) << (8 * k);
        if (sx && nb < 4 && rd[8*nb-1]) rd |= ~((32'h1 << (8 * nb)) - 32'h1);
      end
    end
  endfunction

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
    if (n > 0) split_pend = 1'b0;
  endtask

  // Called and returns at a negedge; the request is sampled at the posedge in between.
  task automatic issue(input logic [31:0] a, input bit we, input logic [1:0] sz, input bit sx,
                       input logic [31:0] wd, input bit use_exp = 1'b0,
                       input logic [31:0] xd = 32'h0, input bit push = 1'b1);
    logic [31:0] rd;
    bit          err;
    bit          sp;
    exp_t        e;
    chk("req_ready", 32'(bus.req_ready), split_pend ? 32'd0 : 32'd1);
    if (split_pend) begin
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("req_ready_after_split", 32'(bus.req_ready), 32'd1);
    end
    bus.req_valid       = 1'b1;
    bus.req_addr        = a;
    bus.req_write_en    = we;
    bus.req_size        = sz;
    bus.req_sign_extend = sx;
    bus.req_write_data  = wd;
    model(a, we, sz, sx, wd, rd, err, sp);
    if (push) begin
      e.data = use_exp ? xd : rd;
      e.err  = err;
      e.cyc  = cyc + (sp ? 2 : 1);
      sb.push_back(e);
    end
    split_pend = sp;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, want no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("rsp_read_data", bus.rsp_read_data, mon_e.data);
        chk("rsp_error", 32'(bus.rsp_error), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    bus.req_valid       = 1'b0;
    bus.req_addr        = '0;
    bus.req_write_en    = 1'b0;
    bus.req_size        = '0;
    bus.req_sign_extend = 1'b0;
    bus.req_write_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_read_data", bus.rsp_read_data, 32'd0);
    chk("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 64; w++) issue(32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom);
    for (int w = DEPTH - 4; w < DEPTH; w++) issue(32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom);

    issue(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    issue(32'h13, 1'b1, 2'd0, 1'b0, 32'h80);
    issue(32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, 32'hFFFFFF80);
    issue(32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h00000080);
    issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h80ADBEEF);
    issue(32'h10, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1, 32'hFFFFBEEF);
    issue(32'h12, 1'b0, 2'd1, 1'b0, 32'h0, 1'b1, 32'h000080AD);

    issue(32'h20, 1'b1, 2'd2, 1'b0, 32'h0);
    issue(32'h24, 1'b1, 2'd2, 1'b0, 32'h0);
    issue(32'h21, 1'b1, 2'd2, 1'b0, 32'h11223344);
    issue(32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, SPLIT_EN ? 32'h22334400 : 32'h0);
    issue(32'h24, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, SPLIT_EN ? 32'h00000011 : 32'h0);

    issue(TOP, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(TOP - 32'd4, 1'b0, 2'd2, 1'b0, 32'h0);
    issue(TOP - 32'd1, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1, 32'h0);
    issue(32'h10, 1'b1, 2'd3, 1'b0, 32'h12345678);
    issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h80ADBEEF);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 248));
      else if (r == 8) a = TOP - 32'd16 + 32'($urandom_range(0, 19));
      else             a = $urandom | 32'h8000_0000;
      r  = $urandom_range(0, 7);
      sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef DMEM_MISALIGNED_SPLIT_EN
    issue(32'h20, 1'b1, 2'd2, 1'b0, 32'h0);
    issue(32'h24, 1'b1, 2'd2, 1'b0, 32'h0);
    idle(3);
    issue(32'h21, 1'b1, 2'd2, 1'b0, 32'h11223344, 1'b0, 32'h0, 1'b0);
    // Reset lands in the SPLIT cycle: word W keeps its new bytes, word W+1 is never written.
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    mdl[32'h24]   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    split_pend = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after_reset", 32'(bus.rsp_valid), 32'd0);
    issue(32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h22334400);
    issue(32'h24, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h00000000);
`endif

    idle(1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    chk("pending_responses", 32'(sb.size()), 32'd0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the core's load/store port. It accepts byte, half and word requests through a valid/ready handshake and stores data in a little-endian word array with byte lanes. Reads are sign- or zero-extended and returned right-justified. It sits between the RV32I datapath's load/store unit and on-chip data RAM, and replaces the combinational data-memory model.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 to DEPTH_WORDS*4-1.
- XLEN, 32: data width; only 32 is supported.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder accepts the request this cycle.
- req_addr  in  32  byte address.
- req_write_en  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_sign_extend  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_write_data  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_read_data  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  request was rejected; memory is unchanged.

## Operation
- A request is accepted when req_valid && req_ready.
- States are IDLE and SPLIT. req_ready = (state == IDLE).
- Aligned access:
  - Performed in the acceptance cycle: the word is read, or the byte lanes are written per size and addr[1:0].
  - The response registers are loaded at the same edge.
- Load data is shifted down by addr[1:0]*8, then extended from bit 7 (byte) or bit 15 (half) per req_sign_extend. A word is returned unchanged.
- Errors, checked at acceptance:
  - req_size == 3.
  - Any touched byte lies at or above DEPTH_WORDS*4. For a split access, both words are checked before anything is written.
  - On error: rsp_error=1, rsp_read_data=0, no write, latency 1.
- Misalignment means a half with addr[0]=1, or a word with addr[1:0]!=0. Handling depends on the macro (see Configuration).
- SPLIT operation:
  - The acceptance cycle accesses word W = addr[31:2] for the lanes from addr[1:0] up to byte 3.
  - The FSM goes to SPLIT and latches the remaining bytes, size, extend mode and partial read data.
  - The SPLIT cycle accesses word W+1, lanes 0 upward. The response is registered and the FSM returns to IDLE.
- Memory contents are not reset. Contents at power-up are undefined.

## Timing
- Reset values: rsp_valid=0, rsp_read_data=0, rsp_error=0, state=IDLE, so req_ready=1 once reset is released.
- Aligned access or error: rsp_valid exactly 1 cycle after acceptance. A new request may be accepted in that same cycle, giving throughput of 1 per cycle.
- Split access: rsp_valid 2 cycles after acceptance. req_ready=0 for exactly 1 cycle.
- Write-then-read of the same address on consecutive cycles returns the new data; the write is committed at the acceptance edge.
- Reset asserted mid-SPLIT:
  - FSM returns to IDLE immediately and no response is issued.
  - Bytes already written to word W persist; word W+1 is untouched.
- rsp_valid never stays high longer than 1 cycle without a new acceptance.

## Configuration
- DMEM_MISALIGNED_SPLIT_EN defined: misaligned in-range accesses use the two-cycle SPLIT sequence, and the SPLIT state and latches are compiled in.
- DMEM_MISALIGNED_SPLIT_EN undefined:
  - Misaligned accesses are errors (rsp_error=1, no write, latency 1).
  - The SPLIT state does not exist, so req_ready is constant 1.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rsp_valid 1 cycle after each acceptance, rsp_read_data=0xDEADBEEF, rsp_error=0.
- Store byte 0x80 to 0x13, then:
  - signed byte load from 0x13 -> 0xFFFFFF80;
  - unsigned byte load from 0x13 -> 0x00000080;
  - word load from 0x10 -> 0x80ADBEEF.
- Back-to-back signed half load from 0x10, then unsigned half load from 0x12, on consecutive cycles -> responses on consecutive cycles: 0xFFFFBEEF, then 0x000080AD.
- Words 0x20 and 0x24 zeroed, then store word 0x11223344 to 0x21:
  - with macro: req_ready low 1 cycle, response at +2; word load from 0x20 -> 0x22334400, from 0x24 -> 0x00000011.
  - without macro: rsp_error=1 at +1, and both words still read 0.
- Word load from DEPTH_WORDS*4 -> rsp_error=1, data 0. A store with req_size=3 to 0x10 -> rsp_error=1, and word 0x10 is unchanged.
- With the macro, start the 0x21 split store and assert reset during SPLIT:
  - no rsp_valid, and req_ready=1 after release;
  - word load from 0x20 -> 0x22334400, from 0x24 -> 0x00000000.
